// File: rtl/mma_frame_rx.sv
`default_nettype none
// ============================================================================
// Module  : mma_frame_rx
// Brief   : Host command/frame parser for the matrix multiply accelerator.
//           Loads A/B operand elements, answers ACK/ERR, decodes run strobes.
// Revision: 1.0 - initial release
// ============================================================================
module mma_frame_rx #(
    parameter int MAX_DIM        = 8,
    parameter int ADDR_W         = 6,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_ready,
    input  logic              tx_busy,
    output logic [7:0]        tx_data,
    output logic              tx_begin,
    output logic              wr_en,
    output logic              wr_sel,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic [7:0]        rows_a,
    output logic [7:0]        cols_a,
    output logic [7:0]        rows_b,
    output logic [7:0]        cols_b,
    output logic              mult_start,
    output logic              send_result,
    output logic              frame_err
);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_HDR   = 3'd1;
    localparam logic [2:0] c_DATA  = 3'd2;
    localparam logic [2:0] c_RESP  = 3'd3;
    localparam logic [2:0] c_DRAIN = 3'd4;

    localparam logic [7:0]  c_ACK     = 8'h06;
    localparam logic [7:0]  c_ERR     = 8'hAA;
    localparam logic [31:0] c_MAX_DIM = 32'(MAX_DIM);

    localparam int                 c_TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [c_TMO_W-1:0] c_TMO_SAT  = c_TMO_W'(TIMEOUT_CYCLES);

    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic               r_rx_prev;
    logic [c_TMO_W-1:0] r_tmo_cnt;
    logic [2:0]         r_hdr_cnt;
    logic [55:0]        r_hdr;
    logic [1:0]         r_byte_cnt;
    logic [23:0]        r_word;
    logic [ADDR_W-1:0]  r_addr_cnt;
    logic [ADDR_W-1:0]  r_last_addr;
    logic               r_pend;
    logic [7:0]         r_tx_data;

    logic               w_take;
    logic               w_tmo;
    logic               w_tx_fire;
    logic [63:0]        w_hdr_next;
    logic [31:0]        w_word_next;
    logic [31:0]        w_rows;
    logic [31:0]        w_cols;
    logic               w_hdr_good;
    logic [15:0]        w_count;
    logic               w_last_elem;

    assign w_take      = rx_ready & ~r_rx_prev;
    assign w_tmo       = (r_tmo_cnt >= c_TMO_LAST) & ~w_take;
    assign w_tx_fire   = r_pend & ~tx_busy;
    assign w_hdr_next  = {r_hdr, rx_data};
    assign w_word_next = {r_word, rx_data};
    assign w_rows      = w_hdr_next[63:32];
    assign w_cols      = w_hdr_next[31:0];
    assign w_hdr_good  = (w_rows != 32'd0) && (w_rows <= c_MAX_DIM) &&
                         (w_cols != 32'd0) && (w_cols <= c_MAX_DIM);
    assign w_count     = {8'd0, w_rows[7:0]} * {8'd0, w_cols[7:0]};
    assign w_last_elem = (r_addr_cnt == r_last_addr);

    assign tx_begin = w_tx_fire;
    assign tx_data  = r_tx_data;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_take && (rx_data == 8'h01 || rx_data == 8'h02)) begin
                    w_state_nxt = c_HDR;
                end
            end
            c_HDR: begin
                if (w_take && r_hdr_cnt == 3'd7) begin
                    w_state_nxt = w_hdr_good ? c_DATA : c_DRAIN;
                end else if (w_tmo) begin
                    w_state_nxt = c_IDLE;
                end
            end
            c_DATA: begin
                if (w_take && r_byte_cnt == 2'd3 && w_last_elem) begin
                    w_state_nxt = c_RESP;
                end else if (w_tmo) begin
                    w_state_nxt = c_IDLE;
                end
            end
            c_RESP: begin
                if (w_tx_fire) begin
                    w_state_nxt = c_IDLE;
                end
            end
            c_DRAIN: begin
                if (w_tmo) begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // A later queue request in the same cycle overrides the clear of r_pend.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rx_prev   <= 1'b0;
            r_tmo_cnt   <= '0;
            r_hdr_cnt   <= '0;
            r_hdr       <= '0;
            r_byte_cnt  <= '0;
            r_word      <= '0;
            r_addr_cnt  <= '0;
            r_last_addr <= '0;
            r_pend      <= 1'b0;
            r_tx_data   <= '0;
            wr_en       <= 1'b0;
            wr_sel      <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            rows_a      <= '0;
            cols_a      <= '0;
            rows_b      <= '0;
            cols_b      <= '0;
            mult_start  <= 1'b0;
            send_result <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            r_rx_prev   <= rx_ready;
            wr_en       <= 1'b0;
            mult_start  <= 1'b0;
            send_result <= 1'b0;

            if (w_take) begin
                r_tmo_cnt <= '0;
            end else if (r_tmo_cnt != c_TMO_SAT) begin
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end

            if (w_tx_fire) begin
                r_pend <= 1'b0;
            end

            case (r_state)
                c_IDLE: begin
                    if (w_take) begin
                        case (rx_data)
                            8'h01, 8'h02: begin
                                wr_sel    <= rx_data[1];
                                frame_err <= 1'b0;
                                r_hdr_cnt <= '0;
                            end
                            8'h03: begin
                                mult_start <= 1'b1;
                                frame_err  <= 1'b0;
                            end
                            8'h04: begin
                                send_result <= 1'b1;
                                frame_err   <= 1'b0;
                            end
                            default: begin
                                r_pend    <= 1'b1;
                                r_tx_data <= c_ERR;
                                frame_err <= 1'b1;
                            end
                        endcase
                    end
                end
                c_HDR: begin
                    if (w_take) begin
                        r_hdr     <= w_hdr_next[55:0];
                        r_hdr_cnt <= r_hdr_cnt + 1'b1;
                        if (r_hdr_cnt == 3'd7) begin
                            if (w_hdr_good) begin
                                if (wr_sel) begin
                                    rows_b <= w_rows[7:0];
                                    cols_b <= w_cols[7:0];
                                end else begin
                                    rows_a <= w_rows[7:0];
                                    cols_a <= w_cols[7:0];
                                end
                                r_last_addr <= ADDR_W'(w_count - 16'd1);
                                r_addr_cnt  <= '0;
                                r_byte_cnt  <= '0;
                            end else begin
                                r_pend    <= 1'b1;
                                r_tx_data <= c_ERR;
                                frame_err <= 1'b1;
                            end
                        end
                    end else if (w_tmo) begin
                        r_pend    <= 1'b1;
                        r_tx_data <= c_ERR;
                        frame_err <= 1'b1;
                    end
                end
                c_DATA: begin
                    if (w_take) begin
                        r_word     <= w_word_next[23:0];
                        r_byte_cnt <= r_byte_cnt + 1'b1;
                        if (r_byte_cnt == 2'd3) begin
                            wr_en   <= 1'b1;
                            wr_data <= w_word_next;
                            wr_addr <= r_addr_cnt;
                            if (w_last_elem) begin
                                r_pend    <= 1'b1;
                                r_tx_data <= c_ACK;
                            end else begin
                                r_addr_cnt <= r_addr_cnt + 1'b1;
                            end
                        end
                    end else if (w_tmo) begin
                        r_pend    <= 1'b1;
                        r_tx_data <= c_ERR;
                        frame_err <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mma_frame_rx.sv
`default_nettype none
// ============================================================================
// Module  : tb_mma_frame_rx
// Brief   : Directed stimulus with a queue scoreboard for mma_frame_rx.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mma_frame_rx;

    localparam int c_TMO = 40;

    logic        clk;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        tx_busy;
    logic [7:0]  tx_data;
    logic        tx_begin;
    logic        wr_en;
    logic        wr_sel;
    logic [5:0]  wr_addr;
    logic [31:0] wr_data;
    logic [7:0]  rows_a, cols_a, rows_b, cols_b;
    logic        mult_start;
    logic        send_result;
    logic        frame_err;

    mma_frame_rx #(.MAX_DIM(8), .ADDR_W(6), .TIMEOUT_CYCLES(c_TMO)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_ready(rx_ready),
        .tx_busy(tx_busy), .tx_data(tx_data), .tx_begin(tx_begin),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
        .rows_a(rows_a), .cols_a(cols_a), .rows_b(rows_b), .cols_b(cols_b),
        .mult_start(mult_start), .send_result(send_result), .frame_err(frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        sel;
        logic [5:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_wr[$];
    logic [7:0]  exp_tx[$];
    logic [7:0]  exp_cmd[$];
    logic [31:0] elems[$];
    int          total = 0;
    int          bad   = 0;

    always @(negedge clk) begin
        wr_t        e;
        logic [7:0] b;
        if (wr_en) begin
            total++;
            if (exp_wr.size() == 0) begin
                bad++;
                $display("FAIL wr_unexpected: got sel=%0d addr=%0d data=%h want none", wr_sel, wr_addr, wr_data);
            end else begin
                e = exp_wr.pop_front();
                if ({wr_sel, wr_addr, wr_data} !== e) begin
                    bad++;
                    $display("FAIL wr: got sel=%0d addr=%0d data=%h want sel=%0d addr=%0d data=%h",
                             wr_sel, wr_addr, wr_data, e.sel, e.addr, e.data);
                end
            end
        end
        if (tx_begin) begin
            total++;
            if (tx_busy) begin
                bad++;
                $display("FAIL tx_while_busy: got tx_begin=1 tx_busy=1 want tx_begin=0");
            end else if (exp_tx.size() == 0) begin
                bad++;
                $display("FAIL tx_unexpected: got %h want none", tx_data);
            end else begin
                b = exp_tx.pop_front();
                if (tx_data !== b) begin
                    bad++;
                    $display("FAIL tx_data: got %h want %h", tx_data, b);
                end
            end
        end
        if (mult_start || send_result) begin
            total++;
            if (exp_cmd.size() == 0) begin
                bad++;
                $display("FAIL strobe_unexpected: got mult=%0d send=%0d want none", mult_start, send_result);
            end else begin
                b = exp_cmd.pop_front();
                if ({mult_start, send_result} !== ((b == 8'h03) ? 2'b10 : 2'b01)) begin
                    bad++;
                    $display("FAIL strobe: got mult=%0d send=%0d want cmd %h", mult_start, send_result, b);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_data  = b;
        rx_ready = 1'b1;
        @(posedge clk); #1;
        rx_ready = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string nm);
        for (int i = 0; i < 200; i++) begin
            if (exp_wr.size() + exp_tx.size() + exp_cmd.size() == 0) break;
            @(negedge clk);
        end
        chk(nm, 64'(exp_wr.size() + exp_tx.size() + exp_cmd.size()), 64'd0);
    endtask

    task automatic send_frame(input logic [7:0] cmd, input logic [31:0] r, input logic [31:0] c);
        for (int i = 0; i < elems.size(); i++)
            exp_wr.push_back({(cmd == 8'h02), 6'(i), elems[i]});
        exp_tx.push_back(8'h06);
        send_byte(cmd);
        send_word(r);
        send_word(c);
        for (int i = 0; i < elems.size(); i++) send_word(elems[i]);
    endtask

    task automatic bad_header(input string nm, input logic [7:0] cmd, input logic [31:0] r, input logic [31:0] c);
        exp_tx.push_back(8'hAA);
        send_byte(cmd);
        send_word(r);
        send_word(c);
        wait_drain({nm, "_err"});
        chk({nm, "_ferr"}, 64'(frame_err), 64'd1);
        send_byte(8'h01);
        send_byte(8'h3F);
        idle(c_TMO + 20);
        exp_cmd.push_back(8'h03);
        send_byte(8'h03);
        wait_drain({nm, "_mult"});
        chk({nm, "_ferr_clr"}, 64'(frame_err), 64'd0);
    endtask

    initial begin
        reset    = 1'b0;
        rx_data  = 8'h00;
        rx_ready = 1'b0;
        tx_busy  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ctl", {tx_data, tx_begin, wr_en, wr_sel, wr_addr, mult_start, send_result, frame_err}, 64'd0);
        chk("reset_dat", {wr_data, rows_a, cols_a, rows_b, cols_b}, 64'd0);
        @(posedge clk); #1;
        reset = 1'b1;

        elems = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
        send_frame(8'h01, 32'd2, 32'd2);
        wait_drain("a2x2");
        chk("a2x2_dims", {rows_a, cols_a, rows_b, cols_b, 7'd0, frame_err}, {8'd2, 8'd2, 8'd0, 8'd0, 8'd0});

        elems = '{32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
        send_frame(8'h02, 32'd2, 32'd2);
        wait_drain("b2x2");
        chk("b2x2_dims", {rows_a, cols_a, rows_b, cols_b}, {8'd2, 8'd2, 8'd2, 8'd2});

        elems = '{32'h00000001, 32'h11111111, 32'h22222222, 32'h33333333,
                  32'hC0490FDB, 32'h7F800000, 32'hFFFFFFFF, 32'h80000000};
        send_frame(8'h02, 32'd8, 32'd1);
        wait_drain("b8x1");
        chk("b8x1_dims", {rows_a, cols_a, rows_b, cols_b}, {8'd2, 8'd2, 8'd8, 8'd1});

        bad_header("hdr9x2", 8'h02, 32'd9, 32'd2);
        bad_header("hdr2x0", 8'h01, 32'd2, 32'd0);
        bad_header("hdr_upper", 8'h01, 32'h00000102, 32'd1);
        chk("bad_dims", {rows_a, cols_a, rows_b, cols_b}, {8'd2, 8'd2, 8'd8, 8'd1});

        exp_cmd.push_back(8'h03);
        send_byte(8'h03);
        exp_cmd.push_back(8'h04);
        send_byte(8'h04);
        exp_tx.push_back(8'hAA);
        send_byte(8'h7F);
        wait_drain("cmds");
        chk("cmd7f_ferr", 64'(frame_err), 64'd1);

        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h00);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("midrst_ctl", {tx_data, tx_begin, wr_en, wr_sel, wr_addr, mult_start, send_result, frame_err}, 64'd0);
        chk("midrst_dat", {wr_data, rows_a, cols_a, rows_b, cols_b}, 64'd0);
        @(posedge clk); #1;
        reset = 1'b1;

        elems = '{32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF};
        send_frame(8'h01, 32'd1, 32'd3);
        wait_drain("a1x3");
        chk("a1x3_dims", {rows_a, cols_a, rows_b, cols_b}, {8'd1, 8'd3, 8'd0, 8'd0});

        tx_busy = 1'b1;
        exp_wr.push_back({1'b0, 6'd0, 32'h3F800000});
        exp_tx.push_back(8'hAA);
        send_byte(8'h01);
        send_word(32'd2);
        send_word(32'd2);
        send_word(32'h3F800000);
        send_byte(8'h40);
        idle(c_TMO + 20);
        chk("stall_wr_done", 64'(exp_wr.size()), 64'd0);
        chk("stall_tx_held", 64'(exp_tx.size()), 64'd1);
        chk("stall_state", {rows_a, cols_a, 7'd0, frame_err}, {8'd2, 8'd2, 8'd1});
        tx_busy = 1'b0;
        wait_drain("stall_err");
        exp_cmd.push_back(8'h03);
        send_byte(8'h03);
        wait_drain("stall_idle");

        idle(5);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
